// File: rtl/ddr_data_burst_if.sv
// Sequencer handshake and DDR DQ/DQS pin bundle for ddr_data_burst.
// Defining BURST_CHOP_EN adds the bc4 burst-chop request.
interface ddr_data_burst_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned BL     = 8
);
    localparam int unsigned WORD_W = DATA_W * BL;

    logic              rw_rdy;
    logic              cas_rw;
`ifdef BURST_CHOP_EN
    logic              bc4;
`endif
    logic [WORD_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_pop;
    logic [DATA_W-1:0] dq_rise_o;
    logic [DATA_W-1:0] dq_fall_o;
    logic              dq_oe;
    logic              dqs_rise_o;
    logic              dqs_fall_o;
    logic              dqs_oe;
    logic [DATA_W-1:0] dq_rise_i;
    logic [DATA_W-1:0] dq_fall_i;
    logic [WORD_W-1:0] rd_data;
    logic              rd_valid;
    logic              burst_done;
    logic              rw_overrun;
    logic              wr_underrun;

    modport master (
`ifdef BURST_CHOP_EN
        output bc4,
`endif
        output rw_rdy, cas_rw, wr_data, wr_valid, dq_rise_i, dq_fall_i,
        input  wr_pop, dq_rise_o, dq_fall_o, dq_oe, dqs_rise_o, dqs_fall_o, dqs_oe,
        input  rd_data, rd_valid, burst_done, rw_overrun, wr_underrun
    );

    modport slave (
`ifdef BURST_CHOP_EN
        input  bc4,
`endif
        input  rw_rdy, cas_rw, wr_data, wr_valid, dq_rise_i, dq_fall_i,
        output wr_pop, dq_rise_o, dq_fall_o, dq_oe, dqs_rise_o, dqs_fall_o, dqs_oe,
        output rd_data, rd_valid, burst_done, rw_overrun, wr_underrun
    );
endinterface

// File: rtl/ddr_data_burst.sv
// DDR data-path burst stage: serializes write words onto DQ/DQS and assembles read words.
// Optional burst chop (4 beats via bc4) is enabled with the BURST_CHOP_EN macro.
module ddr_data_burst #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned BL     = 8
) (
    input  logic            clock_t,
    input  logic            reset_n,
    ddr_data_burst_if.slave bus
);
    localparam int unsigned WORD_W = DATA_W * BL;
    localparam int unsigned PAIRS  = BL / 2;
    localparam int unsigned PAIR_W = 2 * DATA_W;
    localparam int unsigned CNT_W  = $clog2(PAIRS) + 1;
    localparam logic [CNT_W-1:0] LAST_FULL = CNT_W'(PAIRS - 1);
    localparam logic [CNT_W-1:0] LAST_CHOP = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, PRE, BURST, POST} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rd_q, rd_d;
    logic              chop_q, chop_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [WORD_W-1:0] cap_q, cap_d;

    logic [DATA_W-1:0] dq_rise_q, dq_rise_d, dq_fall_q, dq_fall_d;
    logic              dq_oe_q, dq_oe_d;
    logic              dqs_rise_q, dqs_rise_d, dqs_fall_q, dqs_fall_d;
    logic              dqs_oe_q, dqs_oe_d;
    logic              wr_pop_q, wr_pop_d;
    logic [WORD_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              done_q, done_d;
    logic              overrun_q, overrun_d;
    logic              underrun_q, underrun_d;

    logic              chop_in;
    logic              accept;
    logic [CNT_W-1:0]  last_cnt;
    logic [WORD_W-1:0] cap_merged;
    logic [PAIR_W-1:0] wr_pair;

`ifdef BURST_CHOP_EN
    assign chop_in = bus.bc4;
`else
    assign chop_in = 1'b0;
`endif

    assign last_cnt = chop_q ? LAST_CHOP : LAST_FULL;

    // Capture register with the current beat pair merged in at its slot
    assign cap_merged = cap_q
                      | (WORD_W'({bus.dq_fall_i, bus.dq_rise_i}) << (PAIR_W * 32'(cnt_q)));

    // Next state plus next values of every registered output
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        chop_d     = chop_q;
        word_d     = word_q;
        cap_d      = cap_q;
        overrun_d  = overrun_q;
        underrun_d = underrun_q;
        rd_data_d  = rd_data_q;
        dq_rise_d  = '0;
        dq_fall_d  = '0;
        dq_oe_d    = 1'b0;
        dqs_rise_d = 1'b0;
        dqs_fall_d = 1'b0;
        dqs_oe_d   = 1'b0;
        wr_pop_d   = 1'b0;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        accept     = 1'b0;
        wr_pair    = '0;

        case (state_q)
            IDLE: accept = bus.rw_rdy;
            PRE: begin
                state_d = BURST;
                cnt_d   = '0;
                if (bus.rw_rdy) overrun_d = 1'b1;
            end
            BURST: begin
                if (bus.rw_rdy) overrun_d = 1'b1;
                if (rd_q) cap_d = cap_merged;
                if (cnt_q == last_cnt) state_d = POST;
                else                   cnt_d   = cnt_q + CNT_W'(1);
            end
            POST: begin
                state_d = IDLE;
                accept  = bus.rw_rdy;
            end
            default: state_d = IDLE;
        endcase

        // New burst accepted from IDLE or back-to-back from POST
        if (accept) begin
            state_d = PRE;
            rd_d    = bus.cas_rw;
            chop_d  = chop_in;
            cap_d   = '0;
            if (!bus.cas_rw) begin
                word_d   = bus.wr_valid ? bus.wr_data : '0;
                wr_pop_d = bus.wr_valid;
                if (!bus.wr_valid) underrun_d = 1'b1;
            end
        end

        wr_pair = PAIR_W'(word_d >> (PAIR_W * 32'(cnt_d)));

        case (state_d)
            PRE: dqs_oe_d = !rd_d;
            BURST: begin
                if (!rd_d) begin
                    dq_oe_d                = 1'b1;
                    dqs_oe_d               = 1'b1;
                    dqs_rise_d             = 1'b1;
                    {dq_fall_d, dq_rise_d} = wr_pair;
                end
            end
            POST: begin
                done_d = 1'b1;
                if (rd_d) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = cap_merged;
                end else begin
                    dqs_oe_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rd_q       <= 1'b0;
            chop_q     <= 1'b0;
            word_q     <= '0;
            cap_q      <= '0;
            dq_rise_q  <= '0;
            dq_fall_q  <= '0;
            dq_oe_q    <= 1'b0;
            dqs_rise_q <= 1'b0;
            dqs_fall_q <= 1'b0;
            dqs_oe_q   <= 1'b0;
            wr_pop_q   <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            chop_q     <= chop_d;
            word_q     <= word_d;
            cap_q      <= cap_d;
            dq_rise_q  <= dq_rise_d;
            dq_fall_q  <= dq_fall_d;
            dq_oe_q    <= dq_oe_d;
            dqs_rise_q <= dqs_rise_d;
            dqs_fall_q <= dqs_fall_d;
            dqs_oe_q   <= dqs_oe_d;
            wr_pop_q   <= wr_pop_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
        end
    end

    assign bus.dq_rise_o   = dq_rise_q;
    assign bus.dq_fall_o   = dq_fall_q;
    assign bus.dq_oe       = dq_oe_q;
    assign bus.dqs_rise_o  = dqs_rise_q;
    assign bus.dqs_fall_o  = dqs_fall_q;
    assign bus.dqs_oe      = dqs_oe_q;
    assign bus.wr_pop      = wr_pop_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.burst_done  = done_q;
    assign bus.rw_overrun  = overrun_q;
    assign bus.wr_underrun = underrun_q;
endmodule

// File: tb/tb_ddr_data_burst.sv
// Directed scoreboard bench for ddr_data_burst (x8, BL8); chop tests run when BURST_CHOP_EN is defined.
module tb_ddr_data_burst;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned BL     = 8;
    localparam int          PAIRS  = 4;

    logic clock_t = 1'b0;
    logic reset_n = 1'b0;

    ddr_data_burst_if #(.DATA_W(DATA_W), .BL(BL)) bus ();
    ddr_data_burst #(.DATA_W(DATA_W), .BL(BL)) dut (
        .clock_t (clock_t),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock_t = ~clock_t;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_beats[$];
    logic [63:0] exp_rd[$];
    logic        exp_pop[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_t);
        #1;
    endtask

    // Drive an accepted request for the coming edge and queue its expected results
    task automatic start(input bit rd, input logic [63:0] wdata, input bit wvalid,
                         input logic [63:0] rdata, input bit bc);
        logic [63:0] w;
        logic [63:0] r;
        int n;
        n = bc ? 2 : PAIRS;
        bus.rw_rdy   = 1'b1;
        bus.cas_rw   = rd;
        bus.wr_data  = wdata;
        bus.wr_valid = wvalid;
`ifdef BURST_CHOP_EN
        bus.bc4      = bc;
`endif
        if (!rd) begin
            w = wvalid ? wdata : 64'h0;
            for (int k = 0; k < n; k++) exp_beats.push_back(w[k*16 +: 16]);
            exp_pop.push_back(wvalid);
        end else begin
            r = bc ? {32'h0, rdata[31:0]} : rdata;
            exp_rd.push_back(r);
        end
    endtask

    // Walk PRE, BURST and POST; ends inside the POST cycle
    task automatic body(input bit rd, input logic [63:0] rdata, input bit bc, input int inject_k);
        int n;
        logic exp_p;
        logic [15:0] eb;
        logic [63:0] er;
        n = bc ? 2 : PAIRS;
        tick();
        bus.rw_rdy   = 1'b0;
        bus.wr_valid = 1'b0;
        if (!rd) begin
            exp_p = (exp_pop.size() != 0) ? exp_pop.pop_front() : 1'b0;
            chk("pre_wr_pop", 64'(bus.wr_pop), 64'(exp_p));
            chk("pre_wr_dqs", 64'({bus.dqs_oe, bus.dqs_rise_o, bus.dqs_fall_o, bus.dq_oe}), 64'b1000);
        end else begin
            chk("pre_rd_oe", 64'({bus.dq_oe, bus.dqs_oe, bus.wr_pop}), 64'd0);
        end
        for (int k = 0; k < n; k++) begin
            tick();
            bus.rw_rdy = 1'b0;
            bus.cas_rw = rd;
            if (k == inject_k) begin
                bus.rw_rdy = 1'b1;
                bus.cas_rw = ~rd;
            end
            chk("burst_done_low", 64'(bus.burst_done), 64'd0);
            if (!rd) begin
                chk("wr_oe", 64'({bus.dq_oe, bus.dqs_oe, bus.dqs_rise_o, bus.dqs_fall_o}), 64'b1110);
                if (bus.dq_oe && exp_beats.size() != 0) begin
                    eb = exp_beats.pop_front();
                    chk("wr_beat", 64'({bus.dq_fall_o, bus.dq_rise_o}), 64'(eb));
                end
            end else begin
                bus.dq_rise_i = rdata[k*16 +: 8];
                bus.dq_fall_i = rdata[k*16+8 +: 8];
                chk("rd_oe", 64'({bus.dq_oe, bus.dqs_oe}), 64'd0);
            end
        end
        tick();
        bus.rw_rdy = 1'b0;
        chk("post_done", 64'(bus.burst_done), 64'd1);
        if (!rd) begin
            chk("post_wr_dqs", 64'({bus.dqs_oe, bus.dqs_rise_o, bus.dqs_fall_o, bus.dq_oe}), 64'b1000);
            chk("post_wr_rdv", 64'(bus.rd_valid), 64'd0);
        end else begin
            chk("post_rd_valid", 64'(bus.rd_valid), 64'd1);
            chk("post_rd_oe", 64'({bus.dq_oe, bus.dqs_oe}), 64'd0);
            if (bus.rd_valid && exp_rd.size() != 0) begin
                er = exp_rd.pop_front();
                chk("rd_data", bus.rd_data, er);
            end
        end
    endtask

    task automatic idle();
        tick();
        chk("idle", 64'({bus.burst_done, bus.dq_oe, bus.dqs_oe, bus.wr_pop, bus.rd_valid}), 64'd0);
    endtask

    logic [63:0] w2, w3, r2;

    initial begin
        bus.rw_rdy    = 1'b0;
        bus.cas_rw    = 1'b0;
        bus.wr_data   = '0;
        bus.wr_valid  = 1'b0;
        bus.dq_rise_i = '0;
        bus.dq_fall_i = '0;
`ifdef BURST_CHOP_EN
        bus.bc4       = 1'b0;
`endif
        w2 = {$urandom, $urandom};
        w3 = {$urandom, $urandom};
        r2 = {$urandom, $urandom};

        repeat (2) tick();
        chk("reset_outs", 64'({bus.dq_rise_o, bus.dq_fall_o, bus.dq_oe, bus.dqs_rise_o,
                               bus.dqs_fall_o, bus.dqs_oe, bus.wr_pop, bus.rd_valid,
                               bus.burst_done, bus.rw_overrun, bus.wr_underrun}), 64'd0);
        chk("reset_rd_data", bus.rd_data, 64'd0);
        reset_n = 1'b1;
        idle();

        // Single write then single read
        start(1'b0, 64'h0807060504030201, 1'b1, 64'h0, 1'b0);
        body(1'b0, 64'h0, 1'b0, -1);
        idle();
        start(1'b1, 64'h0, 1'b0, 64'hA7A6A5A4A3A2A1A0, 1'b0);
        body(1'b1, 64'hA7A6A5A4A3A2A1A0, 1'b0, -1);
        idle();
        chk("flags_clean", 64'({bus.rw_overrun, bus.wr_underrun}), 64'd0);

        // Back-to-back write -> read -> write issued in each POST cycle
        start(1'b0, w2, 1'b1, 64'h0, 1'b0);
        body(1'b0, 64'h0, 1'b0, -1);
        start(1'b1, 64'h0, 1'b0, r2, 1'b0);
        body(1'b1, r2, 1'b0, -1);
        start(1'b0, w3, 1'b1, 64'h0, 1'b0);
        body(1'b0, 64'h0, 1'b0, -1);
        idle();
        chk("rd_data_hold", bus.rd_data, r2);

        // Overrun: extra rw_rdy mid-burst is ignored but flagged
        start(1'b0, 64'h1122334455667788, 1'b1, 64'h0, 1'b0);
        body(1'b0, 64'h0, 1'b0, 1);
        idle();
        idle();
        chk("rw_overrun", 64'(bus.rw_overrun), 64'd1);
        chk("underrun_still0", 64'(bus.wr_underrun), 64'd0);

        // Underrun: write without valid data sends zeros, no pop
        start(1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h0, 1'b0);
        body(1'b0, 64'h0, 1'b0, -1);
        idle();
        chk("wr_underrun", 64'(bus.wr_underrun), 64'd1);

`ifdef BURST_CHOP_EN
        start(1'b1, 64'h0, 1'b0, 64'h5857565554535251, 1'b1);
        body(1'b1, 64'h5857565554535251, 1'b1, -1);
        idle();
        start(1'b0, 64'hCAFEF00DDEADBEEF, 1'b1, 64'h0, 1'b1);
        body(1'b0, 64'h0, 1'b1, -1);
        idle();
`endif

        // Reset during a write burst aborts it at once
        start(1'b0, 64'h0102030405060708, 1'b1, 64'h0, 1'b0);
        tick();
        bus.rw_rdy   = 1'b0;
        bus.wr_valid = 1'b0;
        tick();
        tick();
        chk("pre_abort_oe", 64'({bus.dq_oe, bus.dqs_oe}), 64'b11);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_oe", 64'({bus.dq_oe, bus.dqs_oe}), 64'd0);
        chk("abort_flags", 64'({bus.rw_overrun, bus.wr_underrun, bus.burst_done}), 64'd0);
        tick();
        reset_n = 1'b1;
        exp_beats.delete();
        exp_pop.delete();
        for (int i = 0; i < 6; i++) idle();

        start(1'b0, 64'h00FF00FF00FF00FF, 1'b1, 64'h0, 1'b0);
        body(1'b0, 64'h0, 1'b0, -1);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
